// File: rtl/syn_tle_ksched_if.sv
// syn_tle_ksched_if: groups the command, operand, engine and result
// handshakes of the K-tiling scheduler. The slave modport is the
// scheduler's view; the master modport is the surrounding system's view.
interface syn_tle_ksched_if #(
  parameter int M    = 2,
  parameter int N    = 2,
  parameter int K    = 2,
  parameter int P    = 8,
  parameter int KT_W = 16
);
  // Command
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [KT_W-1:0]       cmd_ktiles_i;
  logic                  cmd_halved_i;
  logic [3:0]            cmd_bitsize_a_i;
  logic [3:0]            cmd_bitsize_b_i;
  logic signed [4*P-1:0] cmd_C_i [M][N];
  // Operand tiles
  logic                  op_valid_i;
  logic                  op_ready_o;
  logic signed [P-1:0]   op_A_i [M][K];
  logic signed [P-1:0]   op_B_i [K][N];
  // Engine input
  logic                  eng_valid_o;
  logic                  eng_ready_i;
  logic signed [P-1:0]   eng_A_o [M][K];
  logic signed [P-1:0]   eng_B_o [K][N];
  logic signed [4*P-1:0] eng_C_o [M][N];
  logic                  eng_halved_o;
  logic [3:0]            eng_bitsize_a_o;
  logic [3:0]            eng_bitsize_b_o;
  // Engine result
  logic                  eng_valid_i;
  logic                  eng_ready_o;
  logic signed [4*P-1:0] eng_D_i [M][N];
  // Final result
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic signed [4*P-1:0] res_D_o [M][N];
  logic                  busy_o;

  modport slave (
    input  cmd_valid_i, cmd_ktiles_i, cmd_halved_i, cmd_bitsize_a_i,
           cmd_bitsize_b_i, cmd_C_i,
    output cmd_ready_o,
    input  op_valid_i, op_A_i, op_B_i,
    output op_ready_o,
    output eng_valid_o, eng_A_o, eng_B_o, eng_C_o, eng_halved_o,
           eng_bitsize_a_o, eng_bitsize_b_o,
    input  eng_ready_i,
    input  eng_valid_i, eng_D_i,
    output eng_ready_o,
    output res_valid_o, res_D_o, busy_o,
    input  res_ready_i
  );

  modport master (
    output cmd_valid_i, cmd_ktiles_i, cmd_halved_i, cmd_bitsize_a_i,
           cmd_bitsize_b_i, cmd_C_i,
    input  cmd_ready_o,
    output op_valid_i, op_A_i, op_B_i,
    input  op_ready_o,
    input  eng_valid_o, eng_A_o, eng_B_o, eng_C_o, eng_halved_o,
           eng_bitsize_a_o, eng_bitsize_b_o,
    output eng_ready_i,
    output eng_valid_i, eng_D_i,
    input  eng_ready_o,
    input  res_valid_o, res_D_o, busy_o,
    output res_ready_i
  );
endinterface

// File: rtl/syn_tle_ksched.sv
// syn_tle_ksched: K-tiling accumulation scheduler in front of the syn_tle
// engine. Accepts one GEMM command, streams ktiles operand tiles through the
// engine one at a time, feeding each tile's result back as the next tile's C,
// and presents the final accumulated result. Optional performance counters
// are enabled by defining KSCHED_PERF_EN.
module syn_tle_ksched #(
  parameter int M    = 2,
  parameter int N    = 2,
  parameter int K    = 2,
  parameter int P    = 8,
  parameter int KT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  syn_tle_ksched_if.slave      bus
`ifdef KSCHED_PERF_EN
  ,
  output logic [31:0]          perf_busy_o,
  output logic [31:0]          perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic signed [4*P-1:0] r_acc [M][N];
  logic [KT_W-1:0]       r_cnt;
  logic [KT_W-1:0]       r_ktiles;
  logic                  r_halved;
  logic [3:0]            r_bsa;
  logic [3:0]            r_bsb;

  logic                  w_cmd_hs;
  logic                  w_op_hs;
  logic                  w_eng_hs;
  logic                  w_res_hs;
  logic                  w_last;

  // Handshakes are qualified by state so that stray valids elsewhere are inert.
  assign w_cmd_hs = (r_state == S_IDLE)  && bus.cmd_valid_i;
  assign w_op_hs  = (r_state == S_ISSUE) && bus.op_valid_i && bus.eng_ready_i;
  assign w_eng_hs = (r_state == S_WAIT)  && bus.eng_valid_i;
  assign w_res_hs = (r_state == S_OUT)   && bus.res_ready_i;
  // Only evaluated in WAIT, where ktiles >= 1, so the decrement never wraps.
  assign w_last   = (r_cnt == (r_ktiles - KT_W'(1)));

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_hs) w_next = (bus.cmd_ktiles_i == '0) ? S_OUT : S_ISSUE;
      S_ISSUE: if (w_op_hs)  w_next = S_WAIT;
      S_WAIT:  if (w_eng_hs) w_next = w_last ? S_OUT : S_ISSUE;
      S_OUT:   if (w_res_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Accumulator, tile counter and latched precision configuration
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_acc    <= '{default: '0};
      r_cnt    <= '0;
      r_ktiles <= '0;
      r_halved <= 1'b0;
      r_bsa    <= '0;
      r_bsb    <= '0;
    end else if (w_cmd_hs) begin
      r_acc    <= bus.cmd_C_i;
      r_cnt    <= '0;
      r_ktiles <= bus.cmd_ktiles_i;
      r_halved <= bus.cmd_halved_i;
      r_bsa    <= bus.cmd_bitsize_a_i;
      r_bsb    <= bus.cmd_bitsize_b_i;
    end else if (w_eng_hs) begin
      // The engine already wrapped the sum; store it verbatim.
      r_acc    <= bus.eng_D_i;
      r_cnt    <= r_cnt + KT_W'(1);
    end
  end

  // Output decode: handshake strobes per state, data paths always driven
  always_comb begin
    bus.cmd_ready_o     = 1'b0;
    bus.op_ready_o      = 1'b0;
    bus.eng_valid_o     = 1'b0;
    bus.eng_ready_o     = 1'b0;
    bus.res_valid_o     = 1'b0;
    bus.eng_A_o         = bus.op_A_i;
    bus.eng_B_o         = bus.op_B_i;
    bus.eng_C_o         = r_acc;
    bus.res_D_o         = r_acc;
    bus.eng_halved_o    = r_halved;
    bus.eng_bitsize_a_o = r_bsa;
    bus.eng_bitsize_b_o = r_bsb;
    bus.busy_o          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  bus.cmd_ready_o = 1'b1;
      S_ISSUE: begin
        bus.eng_valid_o = bus.op_valid_i;
        bus.op_ready_o  = bus.eng_ready_i;
      end
      S_WAIT:  bus.eng_ready_o = 1'b1;
      S_OUT:   bus.res_valid_o = 1'b1;
      default: ;
    endcase
  end

`ifdef KSCHED_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = ((r_state == S_ISSUE) && bus.op_valid_i && !bus.eng_ready_i) ||
                   ((r_state == S_OUT) && !bus.res_ready_i);

  // Saturating busy/stall counters, kept across commands
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_perf_busy != 32'hFFFF_FFFF))
        r_perf_busy <= r_perf_busy + 32'd1;
      if (w_stall && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_busy_o  = r_perf_busy;
  assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_syn_tle_ksched.sv
// tb_syn_tle_ksched: directed, table-driven bench for the K-tiling scheduler
// with a behavioural single-cycle-latency engine (D = C + A*B).
module tb_syn_tle_ksched;
  localparam int M = 2, N = 2, K = 2, P = 8, KT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  syn_tle_ksched_if #(.M(M), .N(N), .K(K), .P(P), .KT_W(KT_W)) bus ();

`ifdef KSCHED_PERF_EN
  logic [31:0] perf_busy, perf_stall;
`endif

  syn_tle_ksched #(.M(M), .N(N), .K(K), .P(P), .KT_W(KT_W)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
`ifdef KSCHED_PERF_EN
    ,
    .perf_busy_o (perf_busy),
    .perf_stall_o(perf_stall)
`endif
  );

  // ---------------- engine model (latency 1) ----------------
  logic                  m_v;
  logic signed [31:0]    m_D [M][N];
  logic                  spur_v;
  logic signed [31:0]    spur_D;
  logic signed [31:0]    t_sum;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_v <= 1'b0;
    end else begin
      if (m_v && bus.eng_ready_o) m_v <= 1'b0;
      if (bus.eng_valid_o && bus.eng_ready_i) begin
        m_v <= 1'b1;
        for (int i = 0; i < M; i++)
          for (int j = 0; j < N; j++) begin
            t_sum = bus.eng_C_o[i][j];
            for (int k = 0; k < K; k++)
              t_sum = t_sum + 32'(bus.eng_A_o[i][k]) * 32'(bus.eng_B_o[k][j]);
            m_D[i][j] <= t_sum;
          end
      end
    end
  end

  always_comb begin
    bus.eng_valid_i = m_v | spur_v;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        bus.eng_D_i[i][j] = spur_v ? spur_D : m_D[i][j];
  end

  // ---------------- monitors ----------------
  int hs_cnt = 0;
  int opr_cnt = 0;
  always @(posedge clk) begin
    if (bus.eng_valid_o && bus.eng_ready_i) hs_cnt <= hs_cnt + 1;
    if (bus.op_ready_o) opr_cnt <= opr_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit res_all(input logic signed [31:0] v);
    res_all = 1'b1;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        if (bus.res_D_o[i][j] !== v) res_all = 1'b0;
  endfunction

  typedef struct {
    string              name;
    int                 kt;
    bit                 halved;
    logic [3:0]         bsa;
    logic [3:0]         bsb;
    logic signed [7:0]  a;
    logic signed [7:0]  b;
    logic signed [31:0] c;
    logic signed [31:0] d;      // expected value of every result element
    int                 eng_hold; // ISSUE cycles with eng_ready_i low
    int                 res_hold; // OUT cycles with res_ready_i low
    bit                 toggle;   // toggle op_valid_i each cycle
    bit                 spur;     // pulse eng_valid_i during OUT
  } vec_t;

  task automatic drive_idle();
    bus.cmd_valid_i = 1'b0;
    bus.op_valid_i  = 1'b0;
    bus.eng_ready_i = 1'b1;
    bus.res_ready_i = 1'b0;
    spur_v = 1'b0;
    spur_D = '0;
  endtask

  task automatic load_cmd(input vec_t v);
    bus.cmd_ktiles_i    = KT_W'(v.kt);
    bus.cmd_halved_i    = v.halved;
    bus.cmd_bitsize_a_i = v.bsa;
    bus.cmd_bitsize_b_i = v.bsb;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) bus.cmd_C_i[i][j] = v.c;
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) bus.op_A_i[i][k] = v.a;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) bus.op_B_i[k][j] = v.b;
  endtask

  // Runs one full command; entered and left just after a falling edge.
  task automatic do_cmd(input vec_t v);
    int  cyc, stall_left, hs0, op0, cfg_bad, unstable;
    bit  got;
    logic signed [31:0] d00;
`ifdef KSCHED_PERF_EN
    logic [31:0] st0;
`endif
    load_cmd(v);
    bus.cmd_valid_i = 1'b1;
    bus.op_valid_i  = 1'b1;
    bus.res_ready_i = 1'b0;
    bus.eng_ready_i = (v.eng_hold == 0);
    #1;
    chk({v.name, " cmd_ready"}, bus.cmd_ready_o, 1);
    hs0 = hs_cnt;
    op0 = opr_cnt;
`ifdef KSCHED_PERF_EN
    st0 = perf_stall;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    cyc = 0; got = 0; cfg_bad = 0; unstable = 0;
    stall_left = v.eng_hold;
    while (!got && cyc < 500) begin
      cyc++;
      if (v.toggle) bus.op_valid_i = ~bus.op_valid_i;
      bus.eng_ready_i = (stall_left == 0);
      #1;
      if (bus.eng_valid_o && !bus.eng_ready_i) stall_left--;
      if (bus.eng_halved_o !== v.halved || bus.eng_bitsize_a_o !== v.bsa ||
          bus.eng_bitsize_b_o !== v.bsb) cfg_bad++;
      if (bus.res_valid_o) got = 1;
      else @(negedge clk);
    end
    chk({v.name, " res_valid seen"}, got, 1);
    if (v.eng_hold == 0 && !v.toggle)
      chk({v.name, " latency"}, cyc, 2 * v.kt + 1);
    d00 = bus.res_D_o[0][0];
    chk({v.name, " res_D"}, res_all(v.d) ? v.d : d00, v.d);
    bus.eng_ready_i = 1'b1;
    for (int h = 0; h < v.res_hold; h++) begin
      if (v.spur && h == 0) begin
        spur_D = 32'sd12345;
        spur_v = 1'b1;
      end
      @(negedge clk);
      spur_v = 1'b0;
      #1;
      if (!res_all(v.d) || !bus.res_valid_o) unstable++;
    end
    if (v.res_hold > 0) chk({v.name, " res_D stable"}, unstable, 0);
    bus.res_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    bus.op_valid_i  = 1'b0;
    #1;
    chk({v.name, " idle after result"}, {bus.busy_o, bus.res_valid_o, bus.cmd_ready_o}, 3'b001);
    chk({v.name, " engine handshakes"}, hs_cnt - hs0, v.kt);
    chk({v.name, " cfg held"}, cfg_bad, 0);
    chk({v.name, " cfg kept in idle"},
        {bus.eng_halved_o, bus.eng_bitsize_a_o, bus.eng_bitsize_b_o},
        {v.halved, v.bsa, v.bsb});
    if (v.kt == 0) chk({v.name, " op_ready never"}, opr_cnt - op0, 0);
`ifdef KSCHED_PERF_EN
    chk({v.name, " perf_stall delta"}, perf_stall - st0, v.eng_hold + v.res_hold);
`endif
  endtask

  vec_t vecs [7];

  initial begin
    int n;
    vec_t rv;
    //            name      kt hv bsa  bsb   a    b    c               d               eh rh tg sp
    vecs[0] = '{"accum",    3, 0, 4'd8, 4'd8, 8'sd1, 8'sd2, 32'sd3,   32'sd15,          0, 0, 0, 0};
    vecs[1] = '{"zero",     0, 0, 4'd8, 4'd8, 8'sd0, 8'sd0, 32'sd7,   32'sd7,           0, 0, 0, 0};
    vecs[2] = '{"prec",     2, 1, 4'd2, 4'd2, 8'sh11, 8'sh11, 32'sd0, 32'sd1156,        0, 0, 0, 0};
    vecs[3] = '{"neg",      1, 0, 4'd4, 4'd8, -8'sd3, 8'sd5, 32'sd100, 32'sd70,         0, 0, 0, 0};
    vecs[4] = '{"wrap",     1, 0, 4'd8, 4'd8, 8'sd127, 8'sd127, 32'sh7FFF_FFF0, 32'sh8000_7DF2, 0, 0, 0, 0};
    vecs[5] = '{"bpress",   2, 0, 4'd8, 4'd8, 8'sd2, 8'sd3, 32'sd1,   32'sd25,          4, 5, 1, 0};
    vecs[6] = '{"spur_out", 0, 0, 4'd8, 4'd8, 8'sd0, 8'sd0, 32'sd7,   32'sd7,           0, 2, 0, 1};

    drive_idle();
    load_cmd(vecs[1]);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("reset cmd_ready/busy", {bus.cmd_ready_o, bus.busy_o}, 2'b10);
    chk("reset valids", {bus.res_valid_o, bus.eng_valid_o, bus.op_ready_o, bus.eng_ready_o}, 4'b0000);
    chk("reset acc", res_all(32'sd0), 1);
    chk("reset cfg", {bus.eng_halved_o, bus.eng_bitsize_a_o, bus.eng_bitsize_b_o}, 9'd0);

    // Spurious engine result while idle must not touch the accumulator.
    spur_D = 32'sd999;
    spur_v = 1'b1;
    @(negedge clk);
    spur_v = 1'b0;
    #1;
    chk("spur idle acc", res_all(32'sd0), 1);

    for (int v = 0; v < 7; v++) do_cmd(vecs[v]);

    // Reset during WAIT of tile 2 of 3.
    load_cmd(vecs[0]);
    bus.cmd_valid_i = 1'b1;
    bus.op_valid_i  = 1'b1;
    bus.eng_ready_i = 1'b1;
    n = hs_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    for (int c = 0; c < 50 && (hs_cnt - n) < 2; c++) @(negedge clk);
    #1;
    chk("midop in WAIT", {bus.eng_ready_o, bus.busy_o}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.op_valid_i = 1'b0;
    #1;
    chk("midop reset busy", bus.busy_o, 0);
    chk("midop reset acc", res_all(32'sd0), 1);
    spur_D = 32'sd77;
    spur_v = 1'b1;
    @(negedge clk);
    spur_v = 1'b0;
    #1;
    chk("midop late result ignored", res_all(32'sd0), 1);
    chk("midop still idle", {bus.busy_o, bus.cmd_ready_o}, 2'b01);
    rv = '{"after_rst", 1, 0, 4'd8, 4'd8, 8'sd1, 8'sd1, 32'sd5, 32'sd7, 0, 0, 0, 0};
    do_cmd(rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/syn_tle_ksched.md
# syn_tle_ksched

K-tiling accumulation scheduler that sits in front of the `syn_tle` matrix-multiply engine. It accepts one GEMM command, streams `ktiles` A/B operand tiles into the engine one at a time, and feeds each tile's result back as the next tile's C input. It returns the final M×N accumulated result on a valid/ready result port. It owns the engine's precision configuration (`halvedPrecision`, `bitSizeA`, `bitSizeB`) for the duration of a command.

## Interface

- `M`, default 2: rows of A, C and D.
- `N`, default 2: columns of B, C and D.
- `K`, default 2: inner dimension of one tile.
- `P`, default 8: operand precision in bits; the accumulator width is 4P.
- `KT_W`, default 16: width of the tile count.

Ports (unpacked arrays follow the engine's shapes):

- `clk_i` in, 1: single clock; all logic is rising-edge.
- `rst_ni` in, 1: synchronous, active-low reset.
- `cmd_valid_i` in, 1 / `cmd_ready_o` out, 1: command handshake.
- `cmd_ktiles_i` in, KT_W: number of K tiles to accumulate.
- `cmd_halved_i` in, 1 / `cmd_bitsize_a_i` in, 4 / `cmd_bitsize_b_i` in, 4: precision configuration.
- `cmd_C_i` in, signed 4P [M][N]: initial bias.
- `op_valid_i` in, 1 / `op_ready_o` out, 1: operand tile handshake.
- `op_A_i` in, signed P [M][K]: A tile.
- `op_B_i` in, signed P [K][N]: B tile.
- `eng_valid_o` out, 1 / `eng_ready_i` in, 1: engine input handshake.
- `eng_A_o`, `eng_B_o`, `eng_C_o` out: operands and accumulator presented to the engine.
- `eng_halved_o` out, 1 / `eng_bitsize_a_o` out, 4 / `eng_bitsize_b_o` out, 4: engine configuration.
- `eng_valid_i` in, 1 / `eng_ready_o` out, 1 / `eng_D_i` in, signed 4P [M][N]: engine result.
- `res_valid_o` out, 1 / `res_ready_i` in, 1 / `res_D_o` out, signed 4P [M][N]: final result.
- `busy_o` out, 1: high in any state other than IDLE.

## Operation

The controller is a four-state FSM: IDLE, ISSUE, WAIT, OUT.

- **IDLE**
  - `cmd_ready_o`=1.
  - On a command handshake: latch ktiles and the precision fields; `acc` <= `cmd_C_i`; `cnt` <= 0.
  - If ktiles==0, go to OUT; otherwise go to ISSUE.
- **ISSUE** (combinational pass-through)
  - `eng_valid_o`=`op_valid_i`, `op_ready_o`=`eng_ready_i`.
  - `eng_A_o`=`op_A_i`, `eng_B_o`=`op_B_i`, `eng_C_o`=`acc`.
  - On a handshake (both valid and ready high), go to WAIT.
- **WAIT**
  - `eng_ready_o`=1.
  - On `eng_valid_i`: `acc` <= `eng_D_i`; `cnt` <= `cnt`+1.
  - If `cnt`==ktiles−1, go to OUT; otherwise go to ISSUE.
- **OUT**
  - `res_valid_o`=1, `res_D_o`=`acc`.
  - On `res_ready_i`, go to IDLE.

Rules that apply in every state:

- Exactly one tile is in flight at a time, because each tile depends on the previous result.
- The `eng_*` configuration outputs hold their latched values from command accept until the return to IDLE. In IDLE they hold their last values.
- `eng_ready_o`=0 outside WAIT. `eng_valid_i` asserted outside WAIT is ignored and does not change `acc`.
- `op_ready_o`=0 outside ISSUE. `cmd_ready_o`=0 outside IDLE.
- No arithmetic is done here. Accumulation wraps modulo 2^(4P) inside the engine; `acc` stores `eng_D_i` verbatim.
- `cnt` is KT_W bits. ktiles = 2^KT_W−1 is legal, and `cnt` never wraps.

## Timing

- Reset values: state=IDLE; `acc`=0; `cnt`=0; latched configuration=0.
  - All valid outputs are 0 and `busy_o`=0.
  - `cmd_ready_o`=1 in the cycle after reset is released.
- A reset asserted in any state takes effect at the next edge: the FSM returns to IDLE, `acc` is cleared, and any in-flight engine result is dropped. The engine is reset by the same `rst_ni`.
- Command accepted at edge 0: ISSUE is active in cycle 1, so `eng_valid_o` can assert in cycle 1.
- For an engine latency L between input and output handshakes, with no stalls:
  - Each tile costs L+1 cycles.
  - `res_valid_o` first asserts ktiles·(L+1)+1 cycles after command accept.
  - For ktiles==0, `res_valid_o` asserts in cycle 1.
- A new command can be accepted in the cycle after the result handshake. There is no back-to-back overlap.
- All outputs are stable while their valid is held high against ready=0.

## Configuration

- `KSCHED_PERF_EN` defined: adds two output ports, `perf_busy_o` [31:0] and `perf_stall_o` [31:0].
  - `perf_busy_o` counts cycles with `busy_o`=1.
  - `perf_stall_o` counts ISSUE cycles where `eng_valid_o`=1 and `eng_ready_i`=0, plus OUT cycles where `res_ready_i`=0.
  - Both reset to 0, saturate at 2^32−1, and are not cleared between commands.
- `KSCHED_PERF_EN` undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan

All scenarios use M=N=K=2, P=8 and an engine with PIPESTAGES=1.

- **Accumulation:** ktiles=3, A all 1, B all 2, bias all 3 -> `res_D_o` all 15 (3+3·4); exactly 3 engine input handshakes; `cnt` progresses 0, 1, 2.
- **Zero tiles:** ktiles=0, bias all 7 -> `res_valid_o` in cycle 1 with `res_D_o` all 7; no engine handshake and `op_ready_o` never asserted.
- **Precision hold:** halved=1, bitSizeA=bitSizeB=2, ktiles=2, A=B=8'h11 -> `eng_halved_o`=1 and bitsizes=2 held stable across both tiles; result equals the engine's single-shot value applied twice.
- **Backpressure:** `eng_ready_i` low for 4 ISSUE cycles, `op_valid_i` toggling, and `res_ready_i` low for 5 OUT cycles -> no lost or duplicated tile; `res_D_o` stable throughout OUT; with `KSCHED_PERF_EN`, `perf_stall_o` increases by exactly 9.
- **Reset mid-op:** `rst_ni` low for one cycle during WAIT of tile 2 of 3 -> IDLE, `acc`=0 and `busy_o`=0 next cycle; a late `eng_valid_i` is ignored; the next command completes correctly.
- **Spurious result:** `eng_valid_i` pulsed in IDLE and in OUT -> `acc` and `res_D_o` unchanged.
